pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MULDIV_CYCLES, default 4, range 1..16: number of cycles a mult/div instruction occupies EX.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of each statistics counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-low, ports CLK and RSTn.
REQ-004 CLK  in  1  rising-edge clock shared with the IF_ID and ID_EX registers.
REQ-005 RSTn  in  1  asynchronous active-low reset.
REQ-006 ID_Op, ID_Funct  in  6 each  opcode [31:26] and funct [5:0] of the instruction in ID.
REQ-007 ID_Rs, ID_Rt  in  5 each  source register fields of the instruction in ID.
REQ-008 EX_Op, EX_Funct  in  6 each  opcode and funct held in ID_EX.
REQ-009 EX_Rt  in  5  rt field held in ID_EX.
REQ-010 EX_BranchTaken  in  1  branch in EX resolved taken this cycle.
REQ-011 CntClr  in  1  synchronous clear of both statistics counters.
REQ-012 PC_En, IF_ID_En, ID_EX_En  out  1 each  load enables for PC, IF_ID and ID_EX.
REQ-013 IF_ID_Flush  out  1  IF_ID loads an all-zero (NOP) word.
REQ-014 ID_EX_Bubble  out  1  ID_EX loads all-zero fields (NOP) instead of ID outputs.
REQ-015 State  out  2  current FSM state, for debug.
REQ-016 StallCount, FlushCount  out  CNT_WIDTH each  saturating event counters.

Function
REQ-017 FSM states SHALL be RUN, MD_BUSY and MD_LAST, plus a 4-bit down-counter cnt.
REQ-018 load_use SHALL be true when EX_Op == LW, EX_Rt != 0, and EX_Rt equals ID_Rs or ID_Rt.
REQ-019 ex_md SHALL be true when EX_Op == 0 and EX_Funct is MULT, MULTU, DIV or DIVU.
REQ-020 Default outputs: PC_En = IF_ID_En = ID_EX_En = 1, IF_ID_Flush = ID_EX_Bubble = 0.
REQ-021 Priority within a cycle SHALL be branch > mult/div > load-use.
REQ-022 Branch (EX_BranchTaken = 1, any state except MD_BUSY): IF_ID_Flush = 1 and ID_EX_Bubble = 1, PC_En = 1, no stall.
REQ-023 Mult/div detect (RUN, ex_md, MULDIV_CYCLES >= 2): PC_En = IF_ID_En = ID_EX_En = 0 this cycle.
REQ-024 On detect, next state SHALL be MD_LAST if MULDIV_CYCLES == 2, else MD_BUSY with cnt = MULDIV_CYCLES-2.
REQ-025 MD_BUSY: all three enables = 0; if cnt == 1 next state MD_LAST, else cnt decrements.
REQ-026 MD_LAST: ex_md SHALL be ignored, otherwise behaves as RUN; next state RUN.
REQ-027 A mult/div SHALL therefore stall PC/IF_ID/ID_EX for exactly MULDIV_CYCLES-1 cycles; MULDIV_CYCLES = 1 gives no stall.
REQ-028 Load-use (RUN or MD_LAST, no branch, no detect): PC_En = 0, IF_ID_En = 0, ID_EX_Bubble = 1, ID_EX_En = 1, for exactly one cycle.
REQ-029 EX_BranchTaken in MD_BUSY SHALL be ignored, because EX holds the mult/div.
REQ-030 StallCount SHALL increment each cycle PC_En = 0, and FlushCount each cycle IF_ID_Flush = 1.
REQ-031 Both counters SHALL saturate at all-ones; CntClr clears them and takes priority over increment.
REQ-032 Control outputs SHALL be combinational from state, cnt and inputs, with no added latency.

Reset
REQ-033 While RSTn = 0: State = RUN, cnt = 0, counters = 0, enables = 1, IF_ID_Flush = ID_EX_Bubble = 0, independent of other inputs.
REQ-034 Reset asserted mid-MD_BUSY SHALL abort the stall immediately, and RUN SHALL resume on the first edge after release.

Structure
REQ-035 Opcode LW (6'b100011), funct codes MULT/MULTU/DIV/DIVU (6'h18..6'h1B) and the state encoding SHALL live in the shared defines.v.
REQ-036 A sub-module sat_counter (CNT_WIDTH, inc, clr) SHALL be instantiated twice, once per statistics counter.

Verification
REQ-037 Load-use: EX_Op = LW, EX_Rt = 5, ID_Rs = 5 -> one cycle with PC_En = 0, IF_ID_En = 0, ID_EX_Bubble = 1; StallCount = 1.
REQ-038 EX_Rt = 0 with ID_Rs = 0 and EX_Op = LW -> no stall.
REQ-039 MULDIV_CYCLES = 4, DIV in EX -> enables low 3 cycles, State RUN->MD_BUSY->MD_BUSY->MD_LAST->RUN; StallCount = 3.
REQ-040 EX_BranchTaken = 1 with load_use true in the same cycle -> IF_ID_Flush = 1, ID_EX_Bubble = 1, PC_En = 1; FlushCount = 1, StallCount = 0.
REQ-041 RSTn low during the second MD_BUSY cycle -> State = RUN and enables = 1 immediately; counters = 0.
REQ-042 Counters preset near all-ones with a continuous stall -> StallCount holds 16'hFFFF; CntClr -> 0 on the next edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: opcode/funct codes
// that matter for hazard detection and the controller state encoding.
package pipe_hazard_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;

  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_MD_LAST = 2'd2
  } state_e;

  // True for the R-type multiply/divide instructions that hold EX for several cycles
  function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_RTYPE) &&
           ((funct == FN_MULT) || (funct == FN_MULTU) ||
            (funct == FN_DIV)  || (funct == FN_DIVU));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of instruction fields seen by the hazard controller and the
// pipeline-register controls and statistics it produces.
interface pipe_hazard_ctrl_if #(parameter int CNT_WIDTH = 16);

  logic [5:0]           ID_Op;
  logic [5:0]           ID_Funct;
  logic [4:0]           ID_Rs;
  logic [4:0]           ID_Rt;
  logic [5:0]           EX_Op;
  logic [5:0]           EX_Funct;
  logic [4:0]           EX_Rt;
  logic                 EX_BranchTaken;
  logic                 CntClr;

  logic                 PC_En;
  logic                 IF_ID_En;
  logic                 ID_EX_En;
  logic                 IF_ID_Flush;
  logic                 ID_EX_Bubble;
  logic [1:0]           State;
  logic [CNT_WIDTH-1:0] StallCount;
  logic [CNT_WIDTH-1:0] FlushCount;

  // Pipeline side: supplies instruction fields, consumes the controls
  modport master (
    output ID_Op, ID_Funct, ID_Rs, ID_Rt, EX_Op, EX_Funct, EX_Rt,
           EX_BranchTaken, CntClr,
    input  PC_En, IF_ID_En, ID_EX_En, IF_ID_Flush, ID_EX_Bubble, State,
           StallCount, FlushCount
  );

  // Controller side
  modport slave (
    input  ID_Op, ID_Funct, ID_Rs, ID_Rt, EX_Op, EX_Funct, EX_Rt,
           EX_BranchTaken, CntClr,
    output PC_En, IF_ID_En, ID_EX_En, IF_ID_Flush, ID_EX_Bubble, State,
           StallCount, FlushCount
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clear wins over increment.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  // Clear, otherwise count up until every bit is set
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a five-stage pipeline: flushes on taken branches,
// freezes the front end while a multi-cycle mult/div occupies EX, and
// inserts a bubble for load-use dependencies. Also keeps stall/flush statistics.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  pipe_hazard_ctrl_if.slave bus
);

  localparam bit         MD_STALLS   = (MULDIV_CYCLES >= 2);
  localparam logic [3:0] MD_CNT_INIT = 4'(MULDIV_CYCLES - 2);

  state_e               state;
  logic [3:0]           cnt;
  logic                 loadUse;
  logic                 exMd;
  logic                 mdDetect;
  logic                 pcEn;
  logic                 ifIdEn;
  logic                 idExEn;
  logic                 ifIdFlush;
  logic                 idExBubble;
  logic [CNT_WIDTH-1:0] stallCount;
  logic [CNT_WIDTH-1:0] flushCount;

  // A load in EX whose destination (non-zero) is read by the instruction in ID
  assign loadUse = (bus.EX_Op == OP_LW) && (bus.EX_Rt != 5'd0) &&
                   ((bus.EX_Rt == bus.ID_Rs) || (bus.EX_Rt == bus.ID_Rt));
  assign exMd    = is_muldiv(bus.EX_Op, bus.EX_Funct);

  // Resolve hazards by priority: mult/div in progress, branch, new mult/div, load-use
  always_comb begin
    pcEn       = 1'b1;
    ifIdEn     = 1'b1;
    idExEn     = 1'b1;
    ifIdFlush  = 1'b0;
    idExBubble = 1'b0;
    mdDetect   = 1'b0;
    if (RSTn) begin
      if (state == ST_MD_BUSY) begin
        pcEn   = 1'b0;
        ifIdEn = 1'b0;
        idExEn = 1'b0;
      end else if (bus.EX_BranchTaken) begin
        ifIdFlush  = 1'b1;
        idExBubble = 1'b1;
      end else if ((state == ST_RUN) && exMd && MD_STALLS) begin
        mdDetect = 1'b1;
        pcEn     = 1'b0;
        ifIdEn   = 1'b0;
        idExEn   = 1'b0;
      end else if (loadUse) begin
        pcEn       = 1'b0;
        ifIdEn     = 1'b0;
        idExBubble = 1'b1;
      end
    end
  end

  // Mult/div sequencing: RUN -> MD_BUSY (cnt cycles) -> MD_LAST -> RUN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mdDetect) begin
            if (MULDIV_CYCLES == 2) begin
              state <= ST_MD_LAST;
            end else begin
              state <= ST_MD_BUSY;
              cnt   <= MD_CNT_INIT;
            end
          end
        end
        ST_MD_BUSY: begin
          if (cnt == 4'd1) begin
            state <= ST_MD_LAST;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_MD_LAST: state <= ST_RUN;
        default:    state <= ST_RUN;
      endcase
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .inc   (~pcEn),
    .clr   (bus.CntClr),
    .count (stallCount)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .inc   (ifIdFlush),
    .clr   (bus.CntClr),
    .count (flushCount)
  );

  assign bus.PC_En        = pcEn;
  assign bus.IF_ID_En     = ifIdEn;
  assign bus.ID_EX_En     = idExEn;
  assign bus.IF_ID_Flush  = ifIdFlush;
  assign bus.ID_EX_Bubble = idExBubble;
  assign bus.State        = state;
  assign bus.StallCount   = stallCount;
  assign bus.FlushCount   = flushCount;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver applies directed and random
// instruction fields each cycle and queues the reference model's prediction;
// a monitor pops and compares on the falling edge.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int MDC  = 4;
  localparam int MAXC = 65535;

  typedef struct {
    logic [5:0] idOp;
    logic [5:0] idFunct;
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic [5:0] exOp;
    logic [5:0] exFunct;
    logic [4:0] exRt;
    bit         br;
    bit         clr;
  } stim_t;

  typedef struct {
    bit         pcEn;
    bit         ifIdEn;
    bit         idExEn;
    bit         flush;
    bit         bubble;
    logic [1:0] state;
    int         stallCnt;
    int         flushCnt;
    bit         detect;
  } exp_t;

  logic  CLK;
  logic  RSTn;
  exp_t  expQ[$];
  int    assertCount;
  int    failCount;

  // Reference model: mdAge counts cycles since a mult/div was accepted (0 = none)
  int    mdAge;
  int    stallCnt;
  int    flushCnt;
  exp_t  lastExp;
  stim_t lastStim;
  bit    lastRstn;

  pipe_hazard_ctrl_if #(.CNT_WIDTH(16)) bus ();

  pipe_hazard_ctrl #(.MULDIV_CYCLES(MDC), .CNT_WIDTH(16)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic stim_t nopStim();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.idOp    = 6'($urandom);
    s.idFunct = 6'($urandom);
    s.idRs    = 5'($urandom_range(0, 7));
    s.idRt    = 5'($urandom_range(0, 7));
    s.exRt    = 5'($urandom_range(0, 7));
    s.exFunct = 6'($urandom);
    case ($urandom_range(0, 3))
      0:       s.exOp = OP_LW;
      1: begin
        s.exOp    = 6'd0;
        s.exFunct = 6'h18 + 6'($urandom_range(0, 3));
      end
      2:       s.exOp = 6'd0;
      default: s.exOp = 6'($urandom);
    endcase
    s.br  = ($urandom_range(0, 7) == 0);
    s.clr = ($urandom_range(0, 31) == 0);
    return s;
  endfunction

  // Expected outputs this cycle from the hazard rules and the model state
  function automatic exp_t predict(stim_t s, bit rstn);
    exp_t e;
    bit   loadUse;
    bit   exMd;
    bit   busy;
    e.pcEn     = 1'b1;
    e.ifIdEn   = 1'b1;
    e.idExEn   = 1'b1;
    e.flush    = 1'b0;
    e.bubble   = 1'b0;
    e.detect   = 1'b0;
    e.stallCnt = stallCnt;
    e.flushCnt = flushCnt;
    e.state    = (mdAge == 0) ? ST_RUN : ((mdAge == MDC - 1) ? ST_MD_LAST : ST_MD_BUSY);
    if (!rstn) return e;
    loadUse = (s.exOp == 6'b100011) && (s.exRt != 0) &&
              ((s.exRt == s.idRs) || (s.exRt == s.idRt));
    exMd    = (s.exOp == 6'd0) && (s.exFunct >= 6'h18) && (s.exFunct <= 6'h1B);
    busy    = (mdAge != 0) && (mdAge != MDC - 1);
    if (busy) begin
      e.pcEn = 0; e.ifIdEn = 0; e.idExEn = 0;
    end else if (s.br) begin
      e.flush = 1; e.bubble = 1;
    end else if ((mdAge == 0) && exMd && (MDC >= 2)) begin
      e.detect = 1; e.pcEn = 0; e.ifIdEn = 0; e.idExEn = 0;
    end else if (loadUse) begin
      e.pcEn = 0; e.ifIdEn = 0; e.bubble = 1;
    end
    return e;
  endfunction

  // Model update at a clock edge, from the previous cycle's inputs and outcome
  task automatic modelAdvance();
    if (!lastRstn) return;
    if (lastExp.detect) mdAge = 1;
    else if (mdAge != 0) mdAge = (mdAge + 1 == MDC) ? 0 : mdAge + 1;
    if (lastStim.clr) begin
      stallCnt = 0;
      flushCnt = 0;
    end else begin
      if (!lastExp.pcEn && stallCnt < MAXC) stallCnt++;
      if (lastExp.flush && flushCnt < MAXC) flushCnt++;
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge and queue the prediction
  task automatic applyStimulus(stim_t s, bit rstn, bit doCheck);
    @(posedge CLK);
    #1;
    modelAdvance();
    bus.ID_Op          = s.idOp;
    bus.ID_Funct       = s.idFunct;
    bus.ID_Rs          = s.idRs;
    bus.ID_Rt          = s.idRt;
    bus.EX_Op          = s.exOp;
    bus.EX_Funct       = s.exFunct;
    bus.EX_Rt          = s.exRt;
    bus.EX_BranchTaken = s.br;
    bus.CntClr         = s.clr;
    RSTn               = rstn;
    if (!rstn) begin
      mdAge    = 0;
      stallCnt = 0;
      flushCnt = 0;
    end
    lastExp  = predict(s, rstn);
    lastStim = s;
    lastRstn = rstn;
    if (doCheck) expQ.push_back(lastExp);
  endtask

  task automatic checkField(string name, int act, int exp);
    assertCount++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0d, required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(exp_t e);
    checkField("PC_En",        int'(bus.PC_En),        int'(e.pcEn));
    checkField("IF_ID_En",     int'(bus.IF_ID_En),     int'(e.ifIdEn));
    checkField("ID_EX_En",     int'(bus.ID_EX_En),     int'(e.idExEn));
    checkField("IF_ID_Flush",  int'(bus.IF_ID_Flush),  int'(e.flush));
    checkField("ID_EX_Bubble", int'(bus.ID_EX_Bubble), int'(e.bubble));
    checkField("State",        int'(bus.State),        int'(e.state));
    checkField("StallCount",   int'(bus.StallCount),   e.stallCnt);
    checkField("FlushCount",   int'(bus.FlushCount),   e.flushCnt);
  endtask

  // Monitor: compare the oldest prediction on every falling edge
  initial begin
    forever begin
      @(negedge CLK);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    assertCount = 0;
    failCount   = 0;
    mdAge       = 0;
    stallCnt    = 0;
    flushCnt    = 0;
    lastRstn    = 0;
    lastStim    = nopStim();
    RSTn        = 1'b0;
    bus.ID_Op = '0; bus.ID_Funct = '0; bus.ID_Rs = '0; bus.ID_Rt = '0;
    bus.EX_Op = '0; bus.EX_Funct = '0; bus.EX_Rt = '0;
    bus.EX_BranchTaken = 1'b0; bus.CntClr = 1'b0;

    // Reset holds defaults regardless of hazard-looking inputs
    for (int i = 0; i < 4; i++) applyStimulus(randStim(), 1'b0, 1'b1);
    applyStimulus(nopStim(), 1'b1, 1'b1);

    // Load-use on rs, then a quiet cycle showing StallCount = 1
    s = nopStim(); s.exOp = OP_LW; s.exRt = 5'd5; s.idRs = 5'd5;
    applyStimulus(s, 1'b1, 1'b1);
    applyStimulus(nopStim(), 1'b1, 1'b1);

    // Load into r0 never stalls
    s = nopStim(); s.exOp = OP_LW; s.exRt = 5'd0; s.idRs = 5'd0;
    applyStimulus(s, 1'b1, 1'b1);

    // DIV held in EX through its whole occupancy, then a quiet cycle
    s = nopStim(); s.exFunct = FN_DIV;
    for (int i = 0; i < MDC; i++) applyStimulus(s, 1'b1, 1'b1);
    applyStimulus(nopStim(), 1'b1, 1'b1);

    // Branch beats a simultaneous load-use
    s = nopStim(); s.exOp = OP_LW; s.exRt = 5'd7; s.idRt = 5'd7; s.br = 1'b1;
    applyStimulus(s, 1'b1, 1'b1);
    applyStimulus(nopStim(), 1'b1, 1'b1);

    // Branch ignored while busy, then reset lands in the second busy cycle
    s = nopStim(); s.exFunct = FN_MULT;
    applyStimulus(s, 1'b1, 1'b1);
    s.br = 1'b1;
    applyStimulus(s, 1'b1, 1'b1);
    applyStimulus(s, 1'b0, 1'b1);
    applyStimulus(nopStim(), 1'b1, 1'b1);
    applyStimulus(nopStim(), 1'b1, 1'b1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(randStim(), ($urandom_range(0, 149) != 0), 1'b1);
    end

    // Continuous load-use stall long enough to saturate StallCount
    s = nopStim(); s.exOp = OP_LW; s.exRt = 5'd3; s.idRs = 5'd3;
    for (int i = 0; i < MAXC + 9; i++) begin
      applyStimulus(s, 1'b1, ((i % 8192) == 0) || (i > MAXC + 4));
    end
    s = nopStim(); s.clr = 1'b1;
    applyStimulus(s, 1'b1, 1'b1);
    applyStimulus(nopStim(), 1'b1, 1'b1);

    repeat (3) @(posedge CLK);
    checkField("queue_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
